// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared encodings for the debug execution controller
// Purpose: FSM state codes, debug command codes and the default drain length
//          shared by the debug-unit RTL.
// Ports:   none (package).
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_STOP = 2'b11
  } cmd_t;

  // EX, MEM and WB must still complete after HALT is decoded in ID.
  localparam int DRAIN_CYCLES_DEF = 3;

  // Drain counter width: enough for the largest legal drain length (15).
  localparam int DRAIN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for debug statistics
// Purpose: counts clock edges where inc_i is high, sticking at all-ones.
// Ports:
//   clock_i  in  1  clock (posedge)
//   reset_i  in  1  synchronous active-high clear
//   inc_i    in  1  increment request for this edge
//   count_o  out W  current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/debug_exec_ctrl.sv
// rtl/debug_exec_ctrl.sv - run/step/stop and HALT-drain controller for the debug pipeline enable
// Purpose: sequences debug front-end commands into the shared pipeline enable,
//          drains EX/MEM/WB after HALT reaches ID, then freezes the pipeline.
// Ports:
//   i_clock            in  1      clock; this block on posedge, pipeline on negedge
//   i_reset            in  1      synchronous active-high reset
//   i_cmd_valid        in  1      command strobe
//   i_cmd              in  2      00 NOP, 01 RUN, 10 STEP, 11 STOP
//   i_halt_in_id       in  1      HALT opcode decoded in ID this cycle
//   o_cmd_ready        out 1      command accepted when valid & ready at posedge
//   o_pipeline_enable  out 1      enable to every pipeline register
//   o_state            out 3      current FSM state code
//   o_done             out 1      one-cycle pulse on entry to HALTED
//   o_cycle_count      out CNT_W  posedges seen with the enable high (saturating)
module debug_exec_ctrl
  import dbg_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic             i_halt_in_id,
  output logic             o_cmd_ready,
  output logic             o_pipeline_enable,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_count
);

  // The DRAIN cycle entered on the HALT edge is the first of DRAIN_CYCLES.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               enable_q;
  logic               ready_q;
  logic               done_q;
  logic               cmd_take;

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    // Commands arriving while not ready are simply dropped.
    cmd_take = i_cmd_valid && ready_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_take && (i_cmd == CMD_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_take && (i_cmd == CMD_STEP)) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // HALT takes priority over a simultaneous STOP so the pipeline
        // never freezes with a half-retired HALT in flight.
        if (i_halt_in_id) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_take && (i_cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_halt_in_id) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_HALTED: begin
        if (cmd_take && (i_cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change only on
  // posedge and are stable at the pipeline's negedge sampling point.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      enable_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      enable_q <= (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
      ready_q  <= (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALTED);
      done_q   <= (state_d == ST_HALTED) && (state_q != ST_HALTED);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clock_i (i_clock),
    .reset_i (i_reset),
    .inc_i   (enable_q),
    .count_o (o_cycle_count)
  );

  assign o_state           = state_q;
  assign o_pipeline_enable = enable_q;
  assign o_cmd_ready       = ready_q;
  assign o_done            = done_q;

endmodule

// File: tb/tb_debug_exec_ctrl.sv
// tb/tb_debug_exec_ctrl.sv - directed bench for debug_exec_ctrl
module tb_debug_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        halt;

  logic        ready, en, done;
  logic [2:0]  state;
  logic [31:0] count;

  logic        ready4, en4, done4;
  logic [2:0]  state4;
  logic [3:0]  count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debug_exec_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_cmd_valid       (cmd_valid),
    .i_cmd             (cmd),
    .i_halt_in_id      (halt),
    .o_cmd_ready       (ready),
    .o_pipeline_enable (en),
    .o_state           (state),
    .o_done            (done),
    .o_cycle_count     (count)
  );

  debug_exec_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_cmd_valid       (cmd_valid),
    .i_cmd             (cmd),
    .i_halt_in_id      (halt),
    .o_cmd_ready       (ready4),
    .o_pipeline_enable (en4),
    .o_state           (state4),
    .o_done            (done4),
    .o_cycle_count     (count4)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick(1);
    cmd_valid = 1'b0;
    cmd       = 2'b00;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; halt = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_en", {31'd0, en}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", {31'd0, ready}, 1);

    // RUN then STOP eight enabled posedges later.
    send(2'b01);
    chk("run_state", {29'd0, state}, 1);
    chk("run_en", {31'd0, en}, 1);
    chk("run_count0", count, 0);
    tick(7);
    send(2'b11);
    chk("stop_state", {29'd0, state}, 0);
    chk("stop_en", {31'd0, en}, 0);
    chk("stop_count", count, 8);
    tick(1);
    chk("idle_count_hold", count, 8);

    // Three single steps.
    for (int s = 0; s < 3; s++) begin
      send(2'b10);
      chk("step_state", {29'd0, state}, 2);
      chk("step_en", {31'd0, en}, 1);
      chk("step_ready", {31'd0, ready}, 0);
      tick(1);
      chk("step_back_idle", {29'd0, state}, 0);
      chk("step_back_en", {31'd0, en}, 0);
      chk("step_back_ready", {31'd0, ready}, 1);
    end
    chk("step_count", count, 11);

    // RUN, HALT in ID, drain three cycles, dropped STEP during drain.
    send(2'b01);
    tick(2);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("drain_state", {29'd0, state}, 3);
    chk("drain_en", {31'd0, en}, 1);
    chk("drain_ready", {31'd0, ready}, 0);
    send(2'b10);
    chk("drain_step_dropped", {29'd0, state}, 3);
    chk("drain_no_done", {31'd0, done}, 0);
    tick(1);
    chk("drain_state3", {29'd0, state}, 3);
    tick(1);
    chk("halted_state", {29'd0, state}, 4);
    chk("halted_done", {31'd0, done}, 1);
    chk("halted_en", {31'd0, en}, 0);
    chk("halted_ready", {31'd0, ready}, 1);
    chk("halted_count", count, 17);
    chk("sat4_count_a", {28'd0, count4}, 15);
    tick(1);
    chk("halted_done_clear", {31'd0, done}, 0);
    chk("halted_count_hold", count, 17);

    // HALTED: RUN ignored, STOP acknowledges, RUN accepted again.
    send(2'b01);
    chk("halted_run_ignored", {29'd0, state}, 4);
    send(2'b11);
    chk("halted_stop", {29'd0, state}, 0);
    send(2'b01);
    chk("rerun", {29'd0, state}, 1);

    // HALT and STOP at the same edge: HALT wins.
    halt = 1'b1; cmd_valid = 1'b1; cmd = 2'b11;
    tick(1);
    halt = 1'b0; cmd_valid = 1'b0; cmd = 2'b00;
    chk("halt_beats_stop", {29'd0, state}, 3);

    // Reset mid-drain.
    tick(1);
    chk("middrain_state", {29'd0, state}, 3);
    rst = 1'b1;
    tick(1);
    chk("rst_drain_state", {29'd0, state}, 0);
    chk("rst_drain_en", {31'd0, en}, 0);
    chk("rst_drain_count", count, 0);
    chk("rst_drain_done", {31'd0, done}, 0);
    rst = 1'b0;
    tick(3);
    chk("rst_drain_nodone", {31'd0, done}, 0);
    chk("rst_drain_idle", {29'd0, state}, 0);

    // STEP with HALT during the step cycle drains automatically.
    send(2'b10);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("step_halt_drain", {29'd0, state}, 3);
    tick(2);
    chk("step_halt_drain2", {29'd0, state}, 3);
    tick(1);
    chk("step_halt_halted", {29'd0, state}, 4);
    chk("step_halt_done", {31'd0, done}, 1);
    chk("step_halt_count", count, 4);
    send(2'b11);

    // Saturation with a 4-bit counter.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send(2'b01);
    tick(20);
    chk("count_20", count, 20);
    chk("sat4_count_b", {28'd0, count4}, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_exec_ctrl.md
Name: debug_exec_ctrl

Overview:
Execution controller that drives the debug-unit pipeline enable shared by all pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It sequences free-run, single-step and stop commands from the debug UART front end. When a HALT instruction reaches ID, it drains the remaining stages and then freezes the pipeline. It also maintains an enabled-cycle counter for the debug report.

Parameters:
DRAIN_CYCLES, 3, cycles the pipeline stays enabled after HALT is flagged in ID (EX, MEM, WB); legal range 1..15
CNT_W, 32, width of enabled-cycle counter

Ports:
i_clock  in  1  system clock; controller logic on posedge, pipeline registers sample on negedge
i_reset  in  1  reset
i_cmd_valid  in  1  command strobe from debug front end
i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 STOP
i_halt_in_id  in  1  decoder flags HALT opcode in ID this cycle
o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready at posedge
o_pipeline_enable  out  1  to i_pipeline_enable of every pipeline register
o_state  out  3  current FSM state encoding
o_done  out  1  one-cycle pulse on entry to HALTED
o_cycle_count  out  CNT_W  number of posedges with o_pipeline_enable=1

Behaviour:
- Reset: i_reset, synchronous, active-high. All state is cleared at a posedge with i_reset=1, which overrides any command or halt at that edge. After reset: state IDLE, o_pipeline_enable=0, o_done=0, o_cycle_count=0, o_cmd_ready=1.
- Reset mid-RUN or mid-DRAIN aborts at once. The drain counter is cleared and there is no o_done pulse.
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Codes 5..7 are illegal and go to IDLE at the next posedge.
- o_pipeline_enable is a registered flag, updated with the state register. It is 1 exactly in RUN, STEP and DRAIN.
- Because the flag changes only on posedge, it is stable at every negedge sampling point.
- o_cmd_ready = 1 in IDLE, RUN and HALTED; 0 in STEP and DRAIN. A command presented while ready=0 is dropped (no queueing).
- IDLE:
  - RUN goes to RUN.
  - STEP goes to STEP.
  - STOP and NOP are ignored.
- RUN:
  - STOP goes to IDLE.
  - i_halt_in_id goes to DRAIN and loads drain counter = DRAIN_CYCLES-1.
  - Halt and STOP at the same edge: halt wins, go to DRAIN.
  - RUN/STEP while in RUN are ignored.
- STEP:
  - Lasts exactly one cycle, so the pipeline advances one negedge.
  - Next state is IDLE, or DRAIN if i_halt_in_id=1 during the STEP cycle. Drain is automatic and needs no further steps.
- DRAIN:
  - Counter decrements each cycle.
  - When counter=0, go to HALTED at the next posedge. The enable is therefore high for exactly DRAIN_CYCLES cycles.
  - i_halt_in_id is ignored here.
- HALTED:
  - Enable is 0 and o_done pulses for the first cycle only.
  - STOP goes to IDLE (acknowledge).
  - RUN/STEP are ignored; software must STOP first.
- o_cycle_count increments at every posedge where o_pipeline_enable=1. It saturates at all-ones and is cleared only by reset.
- Latency: a command accepted at posedge k gives o_pipeline_enable=1 from k to k+1. The first pipeline advance is at the negedge inside that cycle.

Decomposition:
- Shared package dbg_pkg holds:
  - state encodings (ST_IDLE..ST_HALTED, width 3);
  - command codes (CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP);
  - the DRAIN_CYCLES default.
- One sub-module is natural: sat_counter (parameter W; inputs clock, reset, inc; output count with saturation). It is reused elsewhere for debug statistics.
- The FSM and drain counter stay in the top level.

Test Plan:
- Reset then RUN at cycle 2 → enable=1 from cycle 3; STOP at cycle 10 → enable=0 at cycle 11; o_cycle_count=8.
- STEP in IDLE three times, with each strobe sent only after ready returns → three single-cycle enable pulses; state returns to IDLE (0) each time; o_cycle_count=3.
- RUN, then i_halt_in_id at cycle 20 with DRAIN_CYCLES=3 → state 3 for 3 cycles, HALTED at cycle 24, o_done=1 only at cycle 24, enable=0 thereafter.
- i_halt_in_id and STOP at the same posedge in RUN → state DRAIN, not IDLE. A STEP strobe during DRAIN is dropped (ready=0).
- In HALTED: RUN ignored (state stays 4); STOP → IDLE; a subsequent RUN is accepted.
- i_reset asserted mid-DRAIN → next posedge gives state 0, enable=0, count=0, no o_done. Also force CNT_W=4 and run 20 cycles → count holds at 15.
